// File: rtl/alu_uart_ctrl.sv
// -----------------------------------------------------------------------------
// alu_uart_ctrl
//   Sequencer between a UART receiver/transmitter pair and an external
//   combinational ALU. Three received bytes form a frame (operand A,
//   operand B, opcode). They are held on the ALU inputs, the ALU result is
//   captured and handed to the transmitter, and the block re-arms once the
//   transmitter reports completion. A partial frame is abandoned if the
//   gap between two of its bytes grows too long.
//
// Handshake semantics (all pulses are single-cycle, no back-pressure):
//   i_rx_done  : i_rx_data is valid in this cycle only. The byte is either
//                accepted (GET_A/GET_B/GET_OP) or discarded with o_drop.
//   o_tx_start : request to send o_tx_data; o_tx_data stays stable until
//                i_tx_done is seen in WAIT_TX.
//   i_tx_done  : meaningful only in WAIT_TX, ignored everywhere else.
//
// Ports
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_rx_data/done   received byte and its strobe
//   i_tx_done        transmitter finished strobe
//   i_alu_result     combinational ALU output
//   o_datoa/o_datob  registered ALU operands
//   o_opcode         registered ALU opcode (low SIZEOP bits of third byte)
//   o_tx_data        byte for the transmitter
//   o_tx_start       transmit request pulse
//   o_drop           pulse: received byte discarded while busy
//   o_timeout        pulse: partial frame abandoned
//   o_state          current FSM state, for observation only
// -----------------------------------------------------------------------------
module alu_uart_ctrl #(
    parameter int unsigned SIZEDATA = 8,
    parameter int unsigned SIZEOP   = 6,
    parameter int unsigned TIMEOUT  = 1000000
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [SIZEDATA-1:0] i_rx_data,
    input  logic                i_rx_done,
    input  logic                i_tx_done,
    input  logic [SIZEDATA-1:0] i_alu_result,
    output logic [SIZEDATA-1:0] o_datoa,
    output logic [SIZEDATA-1:0] o_datob,
    output logic [SIZEOP-1:0]   o_opcode,
    output logic [SIZEDATA-1:0] o_tx_data,
    output logic                o_tx_start,
    output logic                o_drop,
    output logic                o_timeout,
    output logic [2:0]          o_state
);

    localparam logic [2:0] S_GET_A   = 3'd0;
    localparam logic [2:0] S_GET_B   = 3'd1;
    localparam logic [2:0] S_GET_OP  = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_SEND    = 3'd4;
    localparam logic [2:0] S_WAIT_TX = 3'd5;

    localparam int unsigned          CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             mid_frame;
    logic             busy;
    logic             expired;

    // Timeout only applies between bytes of a frame that has already started.
    assign mid_frame = (state == S_GET_B) || (state == S_GET_OP);
    assign busy      = (state == S_EXEC) || (state == S_SEND) || (state == S_WAIT_TX);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign expired   = mid_frame && !i_rx_done && (cnt == CNT_LAST);

    // Pulses are qualified with reset so a reset cycle never reports events.
    assign o_drop     = !i_reset && i_rx_done && busy;
    assign o_timeout  = !i_reset && expired;
    assign o_tx_start = !i_reset && (state == S_SEND);
    assign o_state    = state;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= S_GET_A;
            cnt       <= '0;
            o_datoa   <= '0;
            o_datob   <= '0;
            o_opcode  <= '0;
            o_tx_data <= '0;
        end else begin
            case (state)
                S_GET_A: begin
                    cnt <= '0;
                    if (i_rx_done) begin
                        o_datoa <= i_rx_data;
                        state   <= S_GET_B;
                    end
                end
                S_GET_B: begin
                    if (i_rx_done) begin
                        o_datob <= i_rx_data;
                        cnt     <= '0;
                        state   <= S_GET_OP;
                    end else if (expired) begin
                        cnt   <= '0;
                        state <= S_GET_A;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GET_OP: begin
                    if (i_rx_done) begin
                        o_opcode <= i_rx_data[SIZEOP-1:0];
                        cnt      <= '0;
                        state    <= S_EXEC;
                    end else if (expired) begin
                        cnt   <= '0;
                        state <= S_GET_A;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    // Operands and opcode settled last cycle; ALU output is valid now.
                    cnt       <= '0;
                    o_tx_data <= i_alu_result;
                    state     <= S_SEND;
                end
                S_SEND: begin
                    cnt   <= '0;
                    state <= S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    // A byte arriving with i_tx_done is dropped, not taken as operand A.
                    cnt <= '0;
                    if (i_tx_done) begin
                        state <= S_GET_A;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_GET_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
module tb_alu_uart_ctrl;

    localparam logic [2:0] S_GET_A   = 3'd0;
    localparam logic [2:0] S_GET_B   = 3'd1;
    localparam logic [2:0] S_GET_OP  = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_WAIT_TX = 3'd5;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic [7:0] alu_result;
    logic [7:0] datoa;
    logic [7:0] datob;
    logic [5:0] opcode;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       drop;
    logic       timeout;
    logic [2:0] state;

    int vectors     = 0;
    int miscompares = 0;

    alu_uart_ctrl #(.SIZEDATA(8), .SIZEOP(6), .TIMEOUT(8)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .i_tx_done    (tx_done),
        .i_alu_result (alu_result),
        .o_datoa      (datoa),
        .o_datob      (datob),
        .o_opcode     (opcode),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .o_drop       (drop),
        .o_timeout    (timeout),
        .o_state      (state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // Reference ALU (MIPS-style function codes); unknown opcodes give 0.
    always_comb begin
        case (opcode)
            6'h20:   alu_result = datoa + datob;
            6'h22:   alu_result = datoa - datob;
            6'h24:   alu_result = datoa & datob;
            6'h25:   alu_result = datoa | datob;
            6'h26:   alu_result = datoa ^ datob;
            6'h27:   alu_result = ~(datoa | datob);
            6'h03:   alu_result = 8'($signed(datoa) >>> datob);
            6'h02:   alu_result = datoa >> datob;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // driver tasks: called at a negedge, return at a later negedge
    task automatic rx(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic rx_chk(input string tag, input logic [7:0] b, input logic exp_drop);
        rx_data = b;
        rx_done = 1'b1;
        #1;
        check({tag, "_drop"}, 8'(drop), 8'(exp_drop));
        check({tag, "_timeout"}, 8'(timeout), 8'h00);
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    // From EXEC (cycle after opcode byte) up to WAIT_TX.
    task automatic to_wait(input string tag, input logic [7:0] exp_res, input logic [5:0] exp_opc);
        check({tag, "_exec_state"}, 8'(state), 8'(S_EXEC));
        check({tag, "_start_early"}, 8'(tx_start), 8'h00);
        @(negedge clk);
        check({tag, "_tx_start"}, 8'(tx_start), 8'h01);
        check({tag, "_tx_data"}, tx_data, exp_res);
        check({tag, "_opcode"}, 8'(opcode), 8'(exp_opc));
        @(negedge clk);
        check({tag, "_start_clr"}, 8'(tx_start), 8'h00);
        check({tag, "_wait_state"}, 8'(state), 8'(S_WAIT_TX));
    endtask

    task automatic finish_tx(input string tag, input logic [7:0] exp_res);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check({tag, "_idle_state"}, 8'(state), 8'(S_GET_A));
        check({tag, "_tx_hold"}, tx_data, exp_res);
    endtask

    task automatic frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input logic [7:0] exp_res);
        rx(a);
        rx(b);
        rx(op);
        to_wait(tag, exp_res, op[5:0]);
        finish_tx(tag, exp_res);
    endtask

    initial begin
        reset   = 1'b1;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", 8'(state), 8'(S_GET_A));
        check("rst_datoa", datoa, 8'h00);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_tx_start", 8'(tx_start), 8'h00);
        reset = 1'b0;
        @(negedge clk);

        // basic add, latency and return to GET_A
        frame("add", 8'h05, 8'h03, 8'h20, 8'h08);
        // subtract, arithmetic and logical shift
        frame("sub", 8'h03, 8'h05, 8'h22, 8'hFE);
        frame("sra", 8'hF0, 8'h02, 8'h03, 8'hFC);
        frame("srl", 8'hF0, 8'h02, 8'h02, 8'h3C);
        // only the low six bits of the third byte form the opcode
        frame("opmask", 8'h05, 8'h03, 8'hE0, 8'h08);
        // undefined opcode still transmits the ALU default
        frame("undef", 8'h0F, 8'hF0, 8'h3F, 8'h00);

        // busy drops in WAIT_TX, including together with i_tx_done
        rx(8'h10);
        rx(8'h20);
        rx(8'h20);
        to_wait("busy", 8'h30, 6'h20);
        rx_chk("busy_wait", 8'hAA, 1'b1);
        check("busy_state_kept", 8'(state), 8'(S_WAIT_TX));
        rx_data = 8'hAA;
        rx_done = 1'b1;
        tx_done = 1'b1;
        #1;
        check("both_drop", 8'(drop), 8'h01);
        @(negedge clk);
        rx_done = 1'b0;
        tx_done = 1'b0;
        check("both_state", 8'(state), 8'(S_GET_A));
        check("both_datoa_kept", datoa, 8'h10);
        // stray i_tx_done while idle is ignored
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("stray_tx_done", 8'(state), 8'(S_GET_A));
        frame("after_drop", 8'h01, 8'h01, 8'h20, 8'h02);

        // timeout after eight idle cycles in GET_B
        rx_chk("to_a", 8'h11, 1'b0);
        repeat (6) @(negedge clk);
        check("to_early", 8'(timeout), 8'h00);
        @(negedge clk);
        check("to_pulse", 8'(timeout), 8'h01);
        check("to_state_pre", 8'(state), 8'(S_GET_B));
        @(negedge clk);
        check("to_clr", 8'(timeout), 8'h00);
        check("to_state", 8'(state), 8'(S_GET_A));
        check("to_datoa_kept", datoa, 8'h11);
        frame("after_to", 8'h02, 8'h03, 8'h20, 8'h05);

        // byte arriving exactly on the expiry cycle is accepted
        rx(8'h33);
        repeat (7) @(negedge clk);
        rx_chk("edge_b", 8'h44, 1'b0);
        check("edge_state", 8'(state), 8'(S_GET_OP));
        check("edge_datob", datob, 8'h44);
        rx(8'h20);
        to_wait("edge", 8'h77, 6'h20);
        finish_tx("edge", 8'h77);

        // reset mid-frame, with a coincident byte
        rx(8'h07);
        rx(8'h09);
        reset   = 1'b1;
        rx_data = 8'h55;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        reset   = 1'b0;
        check("rmid_state", 8'(state), 8'(S_GET_A));
        check("rmid_datoa", datoa, 8'h00);
        check("rmid_datob", datob, 8'h00);
        check("rmid_opcode", 8'(opcode), 8'h00);
        check("rmid_tx_data", tx_data, 8'h00);
        frame("after_rst", 8'h04, 8'h04, 8'h26, 8'h00);
        check("after_rst_datoa", datoa, 8'h04);

        // reset while waiting for TX completion
        rx(8'h01);
        rx(8'h02);
        rx(8'h25);
        to_wait("rtx", 8'h03, 6'h25);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rtx_state", 8'(state), 8'(S_GET_A));
        check("rtx_tx_data", tx_data, 8'h00);
        check("rtx_tx_start", 8'(tx_start), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
